// File: rtl/operand_fetch.sv
// Operand-fetch / issue stage: reads the register file, tracks pending
// destination writes in a busy scoreboard, and issues into one output slot.
module operand_fetch #(
   parameter int unsigned RegisterCount = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [4:0]                    in_rs1_i,
   input  logic [4:0]                    in_rs2_i,
   input  logic [4:0]                    in_rd_i,
   input  logic                          in_rd_write_i,
   input  logic [31:0]                   in_pc_i,
   output logic [1:0][4:0]               rf_read_address_o,
   input  logic [1:0][31:0]              rf_read_data_i,
   input  logic                          wb_enable_i,
   input  logic [4:0]                    wb_address_i,
   input  logic                          flush_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [31:0]                   out_rs1_data_o,
   output logic [31:0]                   out_rs2_data_o,
   output logic [4:0]                    out_rd_o,
   output logic                          out_rd_write_o,
   output logic [31:0]                   out_pc_o,
   output logic [RegisterCount-1:0]      busy_o,
   output logic [31:0]                   stall_count_o
);

   localparam int unsigned CountW = 32;

   logic [RegisterCount-1:0] clear_c;
   logic [RegisterCount-1:0] eff_busy_c;
   logic [RegisterCount-1:0] busy_n_c;
   logic                     hazard_c;
   logic                     slot_free_c;
   logic                     accept_c;
   logic                     stall_c;

   assign rf_read_address_o[0] = in_rs1_i;
   assign rf_read_address_o[1] = in_rs2_i;

   // Retiring writeback lifts the hazard in the same cycle; the RF forwards the data.
   always_comb begin
      clear_c = '0;
      if (wb_enable_i && wb_address_i != '0) clear_c[wb_address_i] = 1'b1;
   end

   assign eff_busy_c  = busy_o & ~clear_c;
   assign hazard_c    = eff_busy_c[in_rs1_i] | eff_busy_c[in_rs2_i]
                      | (in_rd_write_i & eff_busy_c[in_rd_i]);
   assign slot_free_c = !out_valid_o || out_ready_i;
   assign in_ready_o  = !hazard_c && slot_free_c && !flush_i;
   assign accept_c    = in_valid_i && in_ready_o;
   assign stall_c     = in_valid_i && !in_ready_o;

   // Flushed slot releases its destination so nothing waits on a write that never comes.
   always_comb begin
      busy_n_c = eff_busy_c;
      if (flush_i && out_valid_o && out_rd_write_o) busy_n_c[out_rd_o] = 1'b0;
      if (accept_c && in_rd_write_i && in_rd_i != '0) busy_n_c[in_rd_i] = 1'b1;
      busy_n_c[0] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_o         <= '0;
         stall_count_o  <= '0;
         out_valid_o    <= 1'b0;
         out_rs1_data_o <= '0;
         out_rs2_data_o <= '0;
         out_rd_o       <= '0;
         out_rd_write_o <= 1'b0;
         out_pc_o       <= '0;
      end else begin
         busy_o <= busy_n_c;
         if (stall_c && stall_count_o != '1) stall_count_o <= stall_count_o + CountW'(1);
         if (flush_i) begin
            out_valid_o <= 1'b0;
         end else if (accept_c) begin
            out_valid_o    <= 1'b1;
            out_rs1_data_o <= rf_read_data_i[0];
            out_rs2_data_o <= rf_read_data_i[1];
            out_rd_o       <= in_rd_i;
            out_rd_write_o <= in_rd_write_i;
            out_pc_o       <= in_pc_i;
         end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end

`ifndef SYNTHESIS
   a_x0_never_busy: assert property (@(posedge clk_i) disable iff (rst_i) busy_o[0] == 1'b0);
   a_no_accept_on_hazard: assert property (@(posedge clk_i) disable iff (rst_i)
      !(accept_c && hazard_c));
   a_backpressure_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (out_valid_o && !out_ready_i && !flush_i) |=>
         (out_valid_o && $stable(out_pc_o) && $stable(out_rs1_data_o)
          && $stable(out_rs2_data_o) && $stable(out_rd_o) && $stable(out_rd_write_o)));
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus a randomized run against
// a behavioural scoreboard/slot model with a bench-owned register file.
module tb_operand_fetch;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [4:0]       in_rs1_i, in_rs2_i, in_rd_i;
   logic             in_rd_write_i;
   logic [31:0]      in_pc_i;
   logic [1:0][4:0]  rf_read_address_o;
   logic [1:0][31:0] rf_read_data_i;
   logic             wb_enable_i;
   logic [4:0]       wb_address_i;
   logic [31:0]      wb_data;
   logic             flush_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [31:0]      out_rs1_data_o, out_rs2_data_o, out_pc_o;
   logic [4:0]       out_rd_o;
   logic             out_rd_write_o;
   logic [31:0]      busy_o;
   logic [31:0]      stall_count_o;

   logic [31:0]      regs [32];
   logic             tb_clear;
   int               checks = 0;
   int               errors = 0;

   always #5 clk_i = ~clk_i;

   operand_fetch #(.RegisterCount(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i),
      .in_rd_write_i(in_rd_write_i), .in_pc_i(in_pc_i),
      .rf_read_address_o(rf_read_address_o), .rf_read_data_i(rf_read_data_i),
      .wb_enable_i(wb_enable_i), .wb_address_i(wb_address_i),
      .flush_i(flush_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_rs1_data_o(out_rs1_data_o), .out_rs2_data_o(out_rs2_data_o),
      .out_rd_o(out_rd_o), .out_rd_write_o(out_rd_write_o), .out_pc_o(out_pc_o),
      .busy_o(busy_o), .stall_count_o(stall_count_o)
   );

   // Register file: writes on the edge, reads forward same-cycle writeback.
   always @(posedge clk_i) begin
      if (tb_clear) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_enable_i && wb_address_i != 5'd0) begin
         regs[wb_address_i] <= wb_data;
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         if (rf_read_address_o[k] == 5'd0)
            rf_read_data_i[k] = '0;
         else if (wb_enable_i && wb_address_i == rf_read_address_o[k])
            rf_read_data_i[k] = wb_data;
         else
            rf_read_data_i[k] = regs[rf_read_address_o[k]];
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rdw, input logic [31:0] pc);
      in_valid_i = 1'b1; in_rs1_i = rs1; in_rs2_i = rs2; in_rd_i = rd;
      in_rd_write_i = rdw; in_pc_i = pc;
   endtask

   task automatic rf_load(input logic [4:0] a, input logic [31:0] d);
      in_valid_i = 1'b0; wb_enable_i = 1'b1; wb_address_i = a; wb_data = d;
      tick();
      wb_enable_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; tb_clear = 1'b1;
      in_valid_i = 0; in_rs1_i = 0; in_rs2_i = 0; in_rd_i = 0; in_rd_write_i = 0; in_pc_i = 0;
      wb_enable_i = 0; wb_address_i = 0; wb_data = 0; flush_i = 0; out_ready_i = 1;
      tick(); tick();
      rst_i = 1'b0; tb_clear = 1'b0;
      tick();
      checks++; if (busy_o !== 32'd0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy_o); end
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid_o); end
      checks++; if (stall_count_o !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_count_o); end
      checks++; if (out_pc_o !== 32'd0 || out_rs1_data_o !== 32'd0) begin errors++;
         $display("FAIL reset_data pc %h rs1 %h exp 0", out_pc_o, out_rs1_data_o); end
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready_o); end
   endtask

   task automatic test_basic();
      issue(5'd1, 5'd2, 5'd3, 1'b1, 32'h40);
      #1;
      checks++; if (in_ready_o !== 1'b1 || rf_read_address_o[0] !== 5'd1 || rf_read_address_o[1] !== 5'd2) begin
         errors++; $display("FAIL basic_ready rdy %b a0 %0d a1 %0d exp 1/1/2", in_ready_o,
                            rf_read_address_o[0], rf_read_address_o[1]); end
      tick();
      in_valid_i = 1'b0; in_rd_write_i = 1'b0;
      checks++; if (out_valid_o !== 1'b1 || out_rs1_data_o !== 32'd5 || out_rs2_data_o !== 32'd7) begin
         errors++; $display("FAIL basic_out v %b rs1 %h rs2 %h exp 1/5/7", out_valid_o,
                            out_rs1_data_o, out_rs2_data_o); end
      checks++; if (busy_o !== 32'h8 || out_rd_o !== 5'd3 || out_pc_o !== 32'h40) begin
         errors++; $display("FAIL basic_busy busy %h rd %0d pc %h exp 8/3/40", busy_o, out_rd_o, out_pc_o); end
      #1;
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b exp 1", in_ready_o); end
   endtask

   task automatic test_raw();
      issue(5'd3, 5'd0, 5'd4, 1'b1, 32'h44);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL raw_stall_%0d got %b exp 0", i, in_ready_o); end
         tick();
      end
      checks++; if (stall_count_o !== 32'd4) begin errors++; $display("FAIL raw_count got %0d exp 4", stall_count_o); end
      wb_enable_i = 1'b1; wb_address_i = 5'd3; wb_data = 32'h1234;
      #1;
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", in_ready_o); end
      tick();
      wb_enable_i = 1'b0;
      checks++; if (out_rs1_data_o !== 32'h1234 || busy_o !== 32'h10) begin
         errors++; $display("FAIL raw_fwd rs1 %h busy %h exp 1234/10", out_rs1_data_o, busy_o); end
      // Same-cycle retire and re-set of x4: set must win.
      issue(5'd4, 5'd1, 5'd4, 1'b1, 32'h48);
      wb_enable_i = 1'b1; wb_address_i = 5'd4; wb_data = 32'hBEEF;
      #1;
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL setwin_ready got %b exp 1", in_ready_o); end
      tick();
      wb_enable_i = 1'b0; in_valid_i = 1'b0;
      checks++; if (out_rs1_data_o !== 32'hBEEF || busy_o !== 32'h10) begin
         errors++; $display("FAIL setwin rs1 %h busy %h exp beef/10", out_rs1_data_o, busy_o); end
   endtask

   task automatic test_x0();
      issue(5'd0, 5'd0, 5'd0, 1'b1, 32'h50);
      #1;
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL x0_ready1 got %b exp 1", in_ready_o); end
      tick();
      checks++; if (busy_o !== 32'h10 || out_rs1_data_o !== 32'd0) begin
         errors++; $display("FAIL x0_busy busy %h rs1 %h exp 10/0", busy_o, out_rs1_data_o); end
      in_pc_i = 32'h54;
      #1;
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL x0_ready2 got %b exp 1", in_ready_o); end
      tick();
      in_valid_i = 1'b0;
      checks++; if (stall_count_o !== 32'd4 || out_pc_o !== 32'h54) begin
         errors++; $display("FAIL x0_nostall stall %0d pc %h exp 4/54", stall_count_o, out_pc_o); end
      rf_load(5'd4, 32'hBEEF);
   endtask

   task automatic test_backpressure();
      issue(5'd1, 5'd2, 5'd6, 1'b0, 32'h100);
      tick();
      out_ready_i = 1'b0;
      issue(5'd1, 5'd2, 5'd0, 1'b0, 32'h104);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d got %b exp 0", i, in_ready_o); end
         tick();
         checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h100 || out_rs1_data_o !== 32'd5) begin
            errors++; $display("FAIL bp_hold_%0d v %b pc %h rs1 %h exp 1/100/5", i, out_valid_o,
                               out_pc_o, out_rs1_data_o); end
      end
      checks++; if (stall_count_o !== 32'd7) begin errors++; $display("FAIL bp_count got %0d exp 7", stall_count_o); end
      out_ready_i = 1'b1;
      #1;
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", in_ready_o); end
      tick();
      in_valid_i = 1'b0;
      checks++; if (out_pc_o !== 32'h104 || stall_count_o !== 32'd7) begin
         errors++; $display("FAIL bp_next pc %h stall %0d exp 104/7", out_pc_o, stall_count_o); end
   endtask

   task automatic test_flush();
      issue(5'd1, 5'd2, 5'd5, 1'b1, 32'h200);
      tick();
      issue(5'd1, 5'd2, 5'd7, 1'b1, 32'h204);
      flush_i = 1'b1;
      #1;
      checks++; if (busy_o !== 32'h20 || in_ready_o !== 1'b0) begin
         errors++; $display("FAIL flush_pre busy %h rdy %b exp 20/0", busy_o, in_ready_o); end
      tick();
      flush_i = 1'b0; in_valid_i = 1'b0;
      checks++; if (out_valid_o !== 1'b0 || busy_o !== 32'd0) begin
         errors++; $display("FAIL flush_post v %b busy %h exp 0/0", out_valid_o, busy_o); end
      checks++; if (stall_count_o !== 32'd8) begin errors++; $display("FAIL flush_count got %0d exp 8", stall_count_o); end
   endtask

   task automatic test_reset_mid();
      issue(5'd1, 5'd2, 5'd3, 1'b1, 32'h300);
      tick();
      issue(5'd1, 5'd2, 5'd5, 1'b1, 32'h304);
      tick();
      in_valid_i = 1'b0;
      checks++; if (busy_o !== 32'h28 || out_valid_o !== 1'b1) begin
         errors++; $display("FAIL mid_pre busy %h v %b exp 28/1", busy_o, out_valid_o); end
      #2 rst_i = 1'b1;
      #1;
      checks++; if (busy_o !== 32'd0 || out_valid_o !== 1'b0 || stall_count_o !== 32'd0 || out_pc_o !== 32'd0) begin
         errors++; $display("FAIL mid_async busy %h v %b stall %0d pc %h exp 0", busy_o, out_valid_o,
                            stall_count_o, out_pc_o); end
      tick();
      rst_i = 1'b0;
      tick();
      issue(5'd1, 5'd2, 5'd3, 1'b1, 32'h40);
      #1;
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", in_ready_o); end
      tick();
      in_valid_i = 1'b0;
      checks++; if (out_rs1_data_o !== 32'd5 || out_rs2_data_o !== 32'd7 || busy_o !== 32'h8 || out_pc_o !== 32'h40) begin
         errors++; $display("FAIL mid_first rs1 %h rs2 %h busy %h pc %h exp 5/7/8/40", out_rs1_data_o,
                            out_rs2_data_o, busy_o, out_pc_o); end
   endtask

   task automatic test_random();
      logic [31:0] m_busy, m_stall, m_d1, m_d2, m_pc, eb, f1, f2;
      logic        m_valid, m_rdw, rdy, acc;
      logic [4:0]  m_rd;
      rst_i = 1'b1; in_valid_i = 1'b0; tick(); rst_i = 1'b0;
      m_busy = '0; m_stall = '0; m_valid = 0; m_d1 = '0; m_d2 = '0; m_pc = '0; m_rd = '0; m_rdw = 0;
      for (int n = 0; n < 400; n++) begin
         in_valid_i    = ($urandom % 4) != 0;
         in_rs1_i      = 5'($urandom_range(0, 7));
         in_rs2_i      = 5'($urandom_range(0, 7));
         in_rd_i       = 5'($urandom_range(0, 7));
         in_rd_write_i = 1'($urandom % 2);
         in_pc_i       = $urandom;
         wb_enable_i   = 1'($urandom % 2);
         wb_address_i  = 5'($urandom_range(0, 7));
         wb_data       = $urandom;
         out_ready_i   = ($urandom % 4) != 0;
         flush_i       = ($urandom % 16) == 0;
         #1;
         eb = m_busy;
         if (wb_enable_i && wb_address_i != 5'd0) eb[wb_address_i] = 1'b0;
         rdy = !(eb[in_rs1_i] || eb[in_rs2_i] || (in_rd_write_i && eb[in_rd_i]))
               && (!m_valid || out_ready_i) && !flush_i;
         acc = in_valid_i && rdy;
         f1 = (in_rs1_i == 0) ? 32'd0 : (wb_enable_i && wb_address_i == in_rs1_i) ? wb_data : regs[in_rs1_i];
         f2 = (in_rs2_i == 0) ? 32'd0 : (wb_enable_i && wb_address_i == in_rs2_i) ? wb_data : regs[in_rs2_i];
         checks++; if (in_ready_o !== rdy) begin errors++;
            $display("FAIL rnd_ready cyc %0d got %b exp %b", n, in_ready_o, rdy); end
         if (in_valid_i && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
         if (flush_i && m_valid && m_rdw) eb[m_rd] = 1'b0;
         if (acc && in_rd_write_i && in_rd_i != 0) eb[in_rd_i] = 1'b1;
         m_busy = eb;
         if (flush_i) m_valid = 1'b0;
         else if (acc) begin
            m_valid = 1'b1; m_d1 = f1; m_d2 = f2; m_rd = in_rd_i; m_rdw = in_rd_write_i; m_pc = in_pc_i;
         end else if (out_ready_i) m_valid = 1'b0;
         tick();
         checks++; if (out_valid_o !== m_valid || busy_o !== m_busy || stall_count_o !== m_stall) begin errors++;
            $display("FAIL rnd_state cyc %0d v %b busy %h stall %0d exp %b %h %0d", n, out_valid_o, busy_o,
                     stall_count_o, m_valid, m_busy, m_stall); end
         if (m_valid) begin
            checks++; if (out_rs1_data_o !== m_d1 || out_rs2_data_o !== m_d2 || out_pc_o !== m_pc
                          || out_rd_o !== m_rd || out_rd_write_o !== m_rdw) begin errors++;
               $display("FAIL rnd_slot cyc %0d rs1 %h rs2 %h pc %h rd %0d w %b exp %h %h %h %0d %b", n,
                        out_rs1_data_o, out_rs2_data_o, out_pc_o, out_rd_o, out_rd_write_o,
                        m_d1, m_d2, m_pc, m_rd, m_rdw); end
         end
      end
      in_valid_i = 1'b0; wb_enable_i = 1'b0; flush_i = 1'b0;
   endtask

   initial begin
      test_reset();
      rf_load(5'd1, 32'd5);
      rf_load(5'd2, 32'd7);
      test_basic();
      test_raw();
      test_x0();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
